// File: rtl/tlc_pkg.sv
// tlc_pkg: shared traffic-light-controller constants
//   DEBOUNCE_CYCLES_DEFAULT - filter length; the FSM's timing assumptions depend on it too
package tlc_pkg;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: counts consecutive samples differing from the held level
//   clock, reset - clock and async active-high reset
//   in           - synchronized raw level
//   stable       - debounced level
//   rise         - one-cycle pulse, aligned with stable going high
module debounce_filter import tlc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic stable,
  output logic rise
);
  logic [CNT_W-1:0] cnt;
  logic update;
  // Any sample matching stable clears cnt, so update needs an unbroken run
  assign update = (in != stable) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
    end else begin
      cnt    <= (in == stable || update) ? '0 : cnt + CNT_W'(1);
      stable <= update ? in : stable;
      rise   <= update & in;
    end
  end
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: debounces sensor/walk/reprogram levels and latches walk requests
//   clock, reset  - clock and async active-high reset
//   sensor_sync   - synchronized vehicle sensor      -> sensor_level (debounced)
//   wr_sync       - synchronized walk button         -> wr_pulse (debounced rise)
//   prog_sync     - synchronized reprogram button    -> prog_pulse (debounced rise)
//   wr_ack        - FSM served the walk request      -> clears walk_pending
module input_conditioner import tlc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic sensor_sync,
  input  logic wr_sync,
  input  logic prog_sync,
  input  logic wr_ack,
  output logic sensor_level,
  output logic wr_pulse,
  output logic walk_pending,
  output logic prog_pulse
);
  logic sensor_rise_unused, wr_level, prog_level;
  logic wr_rise;
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sensor (
    .clock(clock), .reset(reset), .in(sensor_sync), .stable(sensor_level), .rise(sensor_rise_unused)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_wr (
    .clock(clock), .reset(reset), .in(wr_sync), .stable(wr_level), .rise(wr_pulse)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_prog (
    .clock(clock), .reset(reset), .in(prog_sync), .stable(prog_level), .rise(prog_pulse)
  );
  // The rise is computed from the same edge's inputs as wr_pulse, so pending
  // rises together with the pulse; a fresh press beats a coincident ack.
  assign wr_rise = wr_level == 1'b0 && wr_sync && u_wr.cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) walk_pending <= 1'b0;
    else walk_pending <= wr_rise | (walk_pending & ~wr_ack);
  end
  logic prog_level_unused;
  assign prog_level_unused = prog_level;
endmodule

// File: tb/tb_input_conditioner.sv
module tb_input_conditioner;
  localparam int N0 = 4;
  localparam int N1 = 1;
  logic clock = 0, reset = 1, sensor_sync = 0, wr_sync = 0, prog_sync = 0, wr_ack = 0;
  logic [1:0] sensor_level, wr_pulse, walk_pending, prog_pulse;
  input_conditioner #(.DEBOUNCE_CYCLES(N0)) dut0 (
    .clock(clock), .reset(reset), .sensor_sync(sensor_sync), .wr_sync(wr_sync),
    .prog_sync(prog_sync), .wr_ack(wr_ack), .sensor_level(sensor_level[0]),
    .wr_pulse(wr_pulse[0]), .walk_pending(walk_pending[0]), .prog_pulse(prog_pulse[0])
  );
  input_conditioner #(.DEBOUNCE_CYCLES(N1)) dut1 (
    .clock(clock), .reset(reset), .sensor_sync(sensor_sync), .wr_sync(wr_sync),
    .prog_sync(prog_sync), .wr_ack(wr_ack), .sensor_level(sensor_level[1]),
    .wr_pulse(wr_pulse[1]), .walk_pending(walk_pending[1]), .prog_pulse(prog_pulse[1])
  );
  always #5 clock = ~clock;

  int checks = 0, fails = 0;
  logic [3:0] exp_q[2][$];
  bit stab[2][3];
  bit pend[2];
  bit hist[2][3][$];

  function automatic logic [3:0] dut_out(int d);
    return {sensor_level[d], wr_pulse[d], walk_pending[d], prog_pulse[d]};
  endfunction

  task automatic compare(int d, logic [3:0] got, logic [3:0] exp, string tag);
    string names[4] = '{"prog_pulse", "walk_pending", "wr_pulse", "sensor_level"};
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (got[b] !== exp[b]) begin
        fails++;
        $display("FAIL %s dut%0d %s at %0t: got %b expected %b", tag, d, names[b], $time, got[b], exp[b]);
      end
    end
  endtask

  // Reference: a level flips once the last N samples all disagree with it.
  task automatic model_edge();
    bit inp[3] = '{sensor_sync, wr_sync, prog_sync};
    for (int d = 0; d < 2; d++) begin
      int n = d ? N1 : N0;
      bit rise[3] = '{0, 0, 0};
      if (reset) begin
        pend[d] = 0;
        for (int f = 0; f < 3; f++) begin
          stab[d][f] = 0;
          hist[d][f].delete();
        end
      end else begin
        for (int f = 0; f < 3; f++) begin
          bit all_diff = 1;
          hist[d][f].push_back(inp[f]);
          if (hist[d][f].size() > n) void'(hist[d][f].pop_front());
          foreach (hist[d][f][k]) if (hist[d][f][k] == stab[d][f]) all_diff = 0;
          if (hist[d][f].size() == n && all_diff) begin
            stab[d][f] = inp[f];
            rise[f] = inp[f];
          end
        end
        pend[d] = rise[1] | (pend[d] & ~wr_ack);
      end
      exp_q[d].push_back({stab[d][0], rise[1], pend[d], rise[2]});
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1;
    for (int d = 0; d < 2; d++)
      if (exp_q[d].size() != 0) compare(d, dut_out(d), exp_q[d].pop_front(), "edge");
  end

  task automatic step(bit s, bit w, bit p, bit a);
    sensor_sync = s; wr_sync = w; prog_sync = p; wr_ack = a;
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic do_reset(bit s, bit w, bit p);
    reset = 1; sensor_sync = s; wr_sync = w; prog_sync = p; wr_ack = 0;
    #1;
    for (int d = 0; d < 2; d++) compare(d, dut_out(d), 4'b0000, "async_reset");
    @(posedge clock);
    model_edge();
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    bit s, w, p;
    @(negedge clock);
    do_reset(0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(bit'((i / 2) % 2), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    do_reset(1, 1, 0);
    for (int i = 0; i < 2; i++) step(0, 1, 0, 0);
    do_reset(0, 1, 0);
    for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
    s = 0; w = 0; p = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) s = ~s;
      if ($urandom_range(0, 4) == 0) w = ~w;
      if ($urandom_range(0, 5) == 0) p = ~p;
      if ($urandom_range(0, 149) == 0) do_reset(s, w, p);
      else step(s, w, p, $urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 5 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); i++) @(negedge clock);
    checks++;
    if (exp_q[0].size() != 0 || exp_q[1].size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d expected entries left, required 0", exp_q[0].size(), exp_q[1].size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
